// File: rtl/frame_scheduler.sv
// Double-buffered frame feeder for the LED row scanner: accepts frames, repeats scans
// with a blanking gap, and swaps in a pending frame only at a scan boundary.
module frame_scheduler #(
   parameter int gs           = 8,
   parameter int GAP_CYCLES   = 4,
   parameter int MIN_SCANS    = 2,
   parameter int SCAN_TIMEOUT = 20
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [gs*gs-1:0] frame_i,
   input  logic             frame_valid_i,
   output logic             frame_ready_o,
   input  logic             d_disp_i,
   output logic [gs*gs-1:0] matrix_o,
   output logic             e_disp_o,
   output logic             frame_shown_o,
   output logic             err_o
);

   localparam int N  = gs * gs;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int TW = $clog2(SCAN_TIMEOUT);
   localparam int SW = $clog2(MIN_SCANS + 1);

   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(SCAN_TIMEOUT - 1);
   localparam logic [SW-1:0] SCAN_MIN = SW'(MIN_SCANS);
   localparam logic [SW-1:0] SCAN_PRE = SW'(MIN_SCANS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    pending_q, pending_d;
   logic [N-1:0]    active_q, active_d;
   logic            pending_full_q, pending_full_d;
   logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
   logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
   logic [TW-1:0]   to_cnt_q, to_cnt_d;
   logic            shown_q, shown_d;
   logic            err_q, err_d;
   logic            e_disp_q;
   logic            ready_q;
   logic            accept;

   function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
      return (v >= SCAN_MIN) ? SCAN_MIN : v + 1'b1;
   endfunction

   assign accept = frame_valid_i && !pending_full_q;

   always_comb begin
      state_d        = state_q;
      pending_d      = pending_q;
      active_d       = active_q;
      pending_full_d = pending_full_q;
      scan_cnt_d     = scan_cnt_q;
      gap_cnt_d      = gap_cnt_q;
      to_cnt_d       = to_cnt_q;
      shown_d        = 1'b0;
      err_d          = err_q;

      // A swap needs pending_full, so it never coincides with an accept.
      if (accept) begin
         pending_d      = frame_i;
         pending_full_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (pending_full_q) begin
               active_d       = pending_q;
               pending_full_d = 1'b0;
               scan_cnt_d     = '0;
               to_cnt_d       = '0;
               state_d        = SCAN;
            end
         end
         SCAN: begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (d_disp_i) begin
               scan_cnt_d = sat_inc(scan_cnt_q);
               // Pulse only on the transition into MIN_SCANS, not on later saturated scans.
               shown_d    = (scan_cnt_q == SCAN_PRE);
               gap_cnt_d  = '0;
               state_d    = GAP;
            end else if (to_cnt_q == TO_LAST) begin
               err_d     = 1'b1;
               gap_cnt_d = '0;
               state_d   = GAP;
            end
         end
         GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               to_cnt_d = '0;
               state_d  = SCAN;
               if (pending_full_q && (scan_cnt_q >= SCAN_MIN)) begin
                  active_d       = pending_q;
                  pending_full_d = 1'b0;
                  scan_cnt_d     = '0;
               end
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= IDLE;
         active_q       <= '0;
         pending_full_q <= 1'b0;
         scan_cnt_q     <= '0;
         gap_cnt_q      <= '0;
         to_cnt_q       <= '0;
         shown_q        <= 1'b0;
         err_q          <= 1'b0;
         e_disp_q       <= 1'b0;
         ready_q        <= 1'b1;
      end else begin
         state_q        <= state_d;
         active_q       <= active_d;
         pending_full_q <= pending_full_d;
         scan_cnt_q     <= scan_cnt_d;
         gap_cnt_q      <= gap_cnt_d;
         to_cnt_q       <= to_cnt_d;
         shown_q        <= shown_d;
         err_q          <= err_d;
         e_disp_q       <= (state_d == SCAN);
         ready_q        <= !pending_full_d;
      end
   end

   // Pending data is qualified by pending_full_q, so it needs no reset.
   always_ff @(posedge clk_i) begin
      pending_q <= pending_d;
   end

   assign matrix_o      = active_q;
   assign e_disp_o      = e_disp_q;
   assign frame_ready_o = ready_q;
   assign frame_shown_o = shown_q;
   assign err_o         = err_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Scoreboard bench for frame_scheduler with an attached row-scanner model.
module tb_frame_scheduler;

   localparam int GS  = 8;
   localparam int GAP = 4;
   localparam int MS  = 2;
   localparam int TO  = 20;

   typedef struct {
      logic [63:0] mtx;
      int          hi;
      bit          shown;
      bit          err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] frame;
   logic        valid;
   logic        ready;
   logic        d_disp;
   logic [63:0] matrix;
   logic        e_disp;
   logic        shown;
   logic        err;
   logic        hold;

   int checks = 0;
   int errors = 0;
   int scans_seen = 0;
   int sc_cnt = 0;

   exp_t exp_q[$];

   localparam logic [63:0] FA = 64'h8142241818244281;
   localparam logic [63:0] FB = 64'h000000000000FFFF;
   localparam logic [63:0] FC = 64'h0123456789ABCDEF;
   localparam logic [63:0] FD = 64'hDEADBEEFCAFEF00D;
   localparam logic [63:0] FE = 64'h00FF00FF00FF00FF;

   frame_scheduler #(
      .gs(GS), .GAP_CYCLES(GAP), .MIN_SCANS(MS), .SCAN_TIMEOUT(TO)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .frame_i(frame),
      .frame_valid_i(valid),
      .frame_ready_o(ready),
      .d_disp_i(d_disp),
      .matrix_o(matrix),
      .e_disp_o(e_disp),
      .frame_shown_o(shown),
      .err_o(err)
   );

   always #5 clk = ~clk;

   // Scanner model: raises done in the (GS+1)-th enabled cycle unless held off.
   always @(posedge clk) begin
      if (!e_disp) sc_cnt <= 0;
      else         sc_cnt <= sc_cnt + 1;
   end
   assign d_disp = e_disp && !hold && (sc_cnt == GS);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, expv);
      end
   endtask

   function automatic exp_t mk(input logic [63:0] m, input int h, input bit s, input bit e);
      exp_t x;
      x.mtx = m; x.hi = h; x.shown = s; x.err = e;
      return x;
   endfunction

   // Monitor: pops one expectation per scan and checks it over the scan's lifetime.
   logic prev_e = 1'b0;
   bit   have_cur = 0;
   bit   gap_valid = 0;
   int   hi_cnt = 0;
   int   lo_cnt = 0;
   exp_t cur;

   always @(negedge clk) begin
      if (e_disp === 1'b1 && prev_e === 1'b0) begin
         scans_seen++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_scan: scan %0d started with no expectation, matrix %h",
                     scans_seen, matrix);
            have_cur = 0;
         end else begin
            cur = exp_q.pop_front();
            have_cur = 1;
            chk($sformatf("scan%0d_matrix", scans_seen), matrix, cur.mtx);
         end
         if (gap_valid) chk($sformatf("scan%0d_gap_len", scans_seen), 64'(lo_cnt), 64'(GAP));
         hi_cnt = 1;
      end else if (e_disp === 1'b1) begin
         hi_cnt++;
      end else if (e_disp === 1'b0 && prev_e === 1'b1) begin
         if (rst === 1'b1) begin
            gap_valid = 0;
         end else if (have_cur) begin
            chk($sformatf("scan%0d_hi_len", scans_seen), 64'(hi_cnt), 64'(cur.hi));
            chk($sformatf("scan%0d_matrix_hold", scans_seen), matrix, cur.mtx);
            chk($sformatf("scan%0d_shown", scans_seen), 64'(shown), 64'(cur.shown));
            chk($sformatf("scan%0d_err", scans_seen), 64'(err), 64'(cur.err));
            gap_valid = 1;
         end
         have_cur = 0;
         lo_cnt = 1;
      end else begin
         lo_cnt++;
      end
      prev_e = e_disp;
   end

   task automatic wait_scans(input int n);
      for (int k = 0; k < 1000 && scans_seen < n; k++) begin
         @(negedge clk); #1;
      end
      chk($sformatf("wait_scans_%0d", n), 64'(scans_seen >= n), 64'd1);
   endtask

   task automatic wait_low();
      for (int k = 0; k < 100 && e_disp !== 1'b0; k++) begin
         @(negedge clk); #1;
      end
      chk("wait_enable_low", 64'(e_disp), 64'd0);
   endtask

   task automatic wait_ready();
      for (int k = 0; k < 200 && ready !== 1'b1; k++) begin
         @(negedge clk); #1;
      end
      chk("wait_ready", 64'(ready), 64'd1);
   endtask

   initial begin
      int bad;
      rst = 1'b1; valid = 1'b0; frame = '0; hold = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      chk("rst_matrix", matrix, 64'd0);
      chk("rst_e_disp", 64'(e_disp), 64'd0);
      chk("rst_ready", 64'(ready), 64'd1);
      chk("rst_shown", 64'(shown), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      rst = 1'b0;

      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); #1;
         if (e_disp !== 1'b0 || matrix !== 64'd0 || ready !== 1'b1) bad++;
      end
      chk("idle_100_cycles_bad", 64'(bad), 64'd0);

      exp_q.push_back(mk(FA, GS + 1, 0, 0));
      exp_q.push_back(mk(FA, GS + 1, 1, 0));
      exp_q.push_back(mk(FB, GS + 1, 0, 0));
      exp_q.push_back(mk(FB, GS + 1, 1, 0));
      exp_q.push_back(mk(FC, GS + 1, 0, 0));
      exp_q.push_back(mk(FC, GS + 1, 1, 0));
      exp_q.push_back(mk(FC, TO, 0, 1));
      exp_q.push_back(mk(FC, GS + 1, 0, 1));

      frame = FA; valid = 1'b1;
      @(posedge clk); @(negedge clk); #1;
      chk("A_ready_low", 64'(ready), 64'd0);
      chk("A_e_disp_still_low", 64'(e_disp), 64'd0);
      valid = 1'b0; frame = '0;
      @(negedge clk); #1;
      chk("A_matrix", matrix, FA);
      chk("A_e_disp_high", 64'(e_disp), 64'd1);
      chk("A_ready_back", 64'(ready), 64'd1);

      wait_scans(1);
      frame = FB; valid = 1'b1;
      @(posedge clk); @(negedge clk); #1;
      chk("B_ready_low", 64'(ready), 64'd0);
      frame = FC;
      wait_ready();
      chk("B_swap_at_scan3", 64'(scans_seen), 64'd3);
      chk("B_matrix_at_swap", matrix, FB);
      @(posedge clk); @(negedge clk); #1;
      valid = 1'b0; frame = '0;
      chk("C_accepted_ready_low", 64'(ready), 64'd0);

      wait_scans(6);
      wait_low();
      hold = 1'b1;
      wait_scans(7);
      wait_low();
      hold = 1'b0;
      chk("err_sticky_after_timeout", 64'(err), 64'd1);

      wait_scans(8);
      frame = FD; valid = 1'b1;
      @(posedge clk); @(negedge clk); #1;
      valid = 1'b0; frame = '0;
      chk("D_ready_low", 64'(ready), 64'd0);
      chk("D_midscan", 64'(e_disp), 64'd1);
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
      @(posedge clk); @(negedge clk); #1;
      chk("rst_mid_e_disp", 64'(e_disp), 64'd0);
      chk("rst_mid_matrix", matrix, 64'd0);
      chk("rst_mid_ready", 64'(ready), 64'd1);
      chk("rst_mid_err", 64'(err), 64'd0);
      @(negedge clk); #1 rst = 1'b0;
      repeat (30) @(negedge clk);
      #1;
      chk("D_discarded_no_scan", 64'(e_disp), 64'd0);
      chk("D_discarded_ready", 64'(ready), 64'd1);

      exp_q.push_back(mk(FE, GS + 1, 0, 0));
      frame = FE; valid = 1'b1;
      @(posedge clk); @(negedge clk); #1;
      valid = 1'b0; frame = '0;
      wait_scans(9);
      wait_low();
      repeat (2) @(negedge clk);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, scans_seen %0d", scans_seen);
      $fatal(1);
   end

endmodule
